// File: rtl/flag_pkg.sv
// Shared definitions for the flag unit: flag bit positions, flag_op encodings,
// default masks and the ALU status-to-flag remap.
package flag_pkg;

    localparam int CF_B = 0;
    localparam int PF_B = 2;
    localparam int AF_B = 4;
    localparam int ZF_B = 6;
    localparam int SF_B = 7;
    localparam int TF_B = 8;
    localparam int IF_B = 9;
    localparam int DF_B = 10;
    localparam int OF_B = 11;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_CLC = 3'd1,
        OP_STC = 3'd2,
        OP_CMC = 3'd3,
        OP_CLD = 3'd4,
        OP_STD = 3'd5,
        OP_CLI = 3'd6,
        OP_STI = 3'd7
    } flag_op_e;

    localparam logic [15:0] FLAG_IMPL_MASK_DEF = 16'h0FD5;
    localparam logic [15:0] SAHF_MASK          = 16'h00D5;

    // s is alu_status[12:4]; s[0] corresponds to status bit 4.
    function automatic logic [15:0] flag_remap(input logic [8:0] s);
        logic [15:0] f;
        f       = '0;
        f[OF_B] = s[8];
        f[DF_B] = s[7];
        f[IF_B] = s[6];
        f[TF_B] = s[5];
        f[SF_B] = s[4];
        f[ZF_B] = s[3];
        f[AF_B] = s[2];
        f[PF_B] = s[1];
        f[CF_B] = s[0];
        return f;
    endfunction

endpackage

// File: rtl/flag_save_stack.sv
// LIFO of saved flag frames for interrupt nesting. A simultaneous push and pop
// does nothing here; the caller treats it as misuse.
module flag_save_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]               ptr;
    logic [DEPTH-1:0][W-1:0]   mem;
    logic                      do_push;
    logic                      do_pop;

    assign full      = (ptr == (AW+1)'(DEPTH));
    assign empty     = (ptr == '0);
    assign do_push   = push & ~pop & ~full;
    assign do_pop    = pop & ~push & ~empty;
    assign overflow  = push & ~pop & full;
    assign underflow = pop & ~push & empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       ptr <= '0;
        else if (do_push) ptr <= ptr + (AW+1)'(1);
        else if (do_pop)  ptr <= ptr - (AW+1)'(1);
    end

    // Frame storage needs no reset: it is unreadable while the pointer is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[ptr[AW-1:0] - AW'(1)];

endmodule

// File: rtl/flag_unit.sv
// 8086 FLAGS register with ALU remap, flag ops, POPF/SAHF loads and interrupt
// save stack. Define FLAG_PARITY_GEN_EN to derive PF from alu_result[7:0].
module flag_unit
    import flag_pkg::*;
#(
    parameter int                    WORD_SIZE      = 16,
    parameter int                    STACK_DEPTH    = 4,
    parameter logic [WORD_SIZE-1:0]  FLAG_IMPL_MASK = WORD_SIZE'(16'h0FD5)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] alu_status,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic                 alu_wr,
    input  logic [WORD_SIZE-1:0] alu_upd_mask,
    input  logic [2:0]           flag_op,
    input  logic                 ld_en,
    input  logic                 ld_low_only,
    input  logic [WORD_SIZE-1:0] ld_data,
    input  logic                 int_enter,
    input  logic                 int_ret,
    input  logic                 err_clr,
    output logic [WORD_SIZE-1:0] result_flag_sig,
    output logic                 stack_empty,
    output logic                 stack_full,
    output logic                 err_sticky
);

    localparam logic [WORD_SIZE-1:0] SAHF_M  = WORD_SIZE'(SAHF_MASK);
    localparam logic [WORD_SIZE-1:0] CF_M    = WORD_SIZE'(1) << CF_B;
    localparam logic [WORD_SIZE-1:0] DF_M    = WORD_SIZE'(1) << DF_B;
    localparam logic [WORD_SIZE-1:0] IF_M    = WORD_SIZE'(1) << IF_B;
    localparam logic [WORD_SIZE-1:0] TF_M    = WORD_SIZE'(1) << TF_B;

    logic [WORD_SIZE-1:0] flags;
    logic [WORD_SIZE-1:0] flags_nxt;
    logic [WORD_SIZE-1:0] remap;
    logic [WORD_SIZE-1:0] pop_data;
    logic                 overflow;
    logic                 underflow;
    logic                 err_set;
    logic                 unused_bits;

`ifdef FLAG_PARITY_GEN_EN
    logic [15:0] remap16;
    always_comb begin
        remap16       = flag_remap(alu_status[12:4]);
        remap16[PF_B] = ~^alu_result[7:0];
    end
    assign remap       = WORD_SIZE'(remap16);
    assign unused_bits = ^{alu_result[WORD_SIZE-1:8], alu_status[WORD_SIZE-1:13],
                           alu_status[5], alu_status[3:0]};
`else
    assign remap       = WORD_SIZE'(flag_remap(alu_status[12:4]));
    assign unused_bits = ^{alu_result, alu_status[WORD_SIZE-1:13], alu_status[3:0]};
`endif

    flag_save_stack #(
        .W     (WORD_SIZE),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (int_enter),
        .pop       (int_ret),
        .push_data (flags),
        .pop_data  (pop_data),
        .full      (stack_full),
        .empty     (stack_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign err_set = overflow | underflow | (int_enter & int_ret);

    // Priority: interrupt stack > load > flag op > ALU write.
    always_comb begin
        flags_nxt = flags;
        if (int_enter && int_ret) begin
            flags_nxt = flags;
        end else if (int_enter) begin
            flags_nxt = flags & ~(IF_M | TF_M);
        end else if (int_ret) begin
            if (!stack_empty) flags_nxt = pop_data;
        end else if (ld_en) begin
            if (ld_low_only) flags_nxt = (flags & ~SAHF_M) | (ld_data & SAHF_M);
            else             flags_nxt = ld_data;
        end else if (flag_op != OP_NOP) begin
            case (flag_op_e'(flag_op))
                OP_CLC:  flags_nxt = flags & ~CF_M;
                OP_STC:  flags_nxt = flags | CF_M;
                OP_CMC:  flags_nxt = flags ^ CF_M;
                OP_CLD:  flags_nxt = flags & ~DF_M;
                OP_STD:  flags_nxt = flags | DF_M;
                OP_CLI:  flags_nxt = flags & ~IF_M;
                OP_STI:  flags_nxt = flags | IF_M;
                default: flags_nxt = flags;
            endcase
        end else if (alu_wr) begin
            flags_nxt = (flags & ~alu_upd_mask) | (remap & alu_upd_mask);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags      <= '0;
            err_sticky <= 1'b0;
        end else begin
            flags <= flags_nxt & FLAG_IMPL_MASK;
            if (err_set)      err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

    assign result_flag_sig = flags;

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit (default parameters).
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_status, alu_result, alu_upd_mask, ld_data;
    logic        alu_wr, ld_en, ld_low_only, int_enter, int_ret, err_clr;
    logic [2:0]  flag_op;
    logic [15:0] result_flag_sig;
    logic        stack_empty, stack_full, err_sticky;

    int n_chk  = 0;
    int n_fail = 0;

    flag_unit dut (
        .clk             (clk),
        .reset           (reset),
        .alu_status      (alu_status),
        .alu_result      (alu_result),
        .alu_wr          (alu_wr),
        .alu_upd_mask    (alu_upd_mask),
        .flag_op         (flag_op),
        .ld_en           (ld_en),
        .ld_low_only     (ld_low_only),
        .ld_data         (ld_data),
        .int_enter       (int_enter),
        .int_ret         (int_ret),
        .err_clr         (err_clr),
        .result_flag_sig (result_flag_sig),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alu_status = '0; alu_result = '0; alu_upd_mask = '0; ld_data = '0;
        alu_wr = 0; ld_en = 0; ld_low_only = 0; int_enter = 0; int_ret = 0;
        err_clr = 0; flag_op = 3'd0;
    endtask

    // Apply the currently driven request for one edge, then sample and go idle.
    task automatic cyc();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic load(input logic [15:0] d);
        ld_en = 1; ld_data = d; cyc();
    endtask

    initial begin
        idle();
        reset = 0;
        #12;
        chk("rst_flags", result_flag_sig, 16'h0000);
        chk("rst_empty", 16'(stack_empty), 16'd1);
        chk("rst_full",  16'(stack_full),  16'd0);
        chk("rst_err",   16'(err_sticky),  16'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;

        // Masked ALU write preserves CF
        load(16'h0001);
        chk("load_cf", result_flag_sig, 16'h0001);
        alu_wr = 1; alu_status = 16'h0180; alu_upd_mask = 16'h00C0; cyc();
        chk("alu_masked", result_flag_sig, 16'h00C1);

        // Flag ops and SAHF
        load(16'h0000);
        flag_op = 3'd2; cyc(); chk("stc", result_flag_sig, 16'h0001);
        flag_op = 3'd3; cyc(); chk("cmc", result_flag_sig, 16'h0000);
        flag_op = 3'd5; cyc(); chk("std", result_flag_sig, 16'h0400);
        flag_op = 3'd7; cyc(); chk("sti", result_flag_sig, 16'h0600);
        ld_en = 1; ld_low_only = 1; ld_data = 16'hFFFF; cyc();
        chk("sahf", result_flag_sig, 16'h06D5);

        // Full remap, reserved bits masked (alu_result=0 gives PF=1 with parity gen)
        alu_wr = 1; alu_status = 16'hFFF0; alu_upd_mask = 16'hFFFF; alu_result = 16'h0000; cyc();
        chk("remap_all", result_flag_sig, 16'h0FD5);
        flag_op = 3'd6; cyc(); chk("cli", result_flag_sig, 16'h0DD5);
        flag_op = 3'd4; cyc(); chk("cld", result_flag_sig, 16'h09D5);
        flag_op = 3'd1; cyc(); chk("clc", result_flag_sig, 16'h09D4);

        // Priority: load beats ALU, flag op beats ALU
        ld_en = 1; ld_data = 16'h0003; alu_wr = 1; alu_status = 16'h1000; alu_upd_mask = 16'hFFFF; cyc();
        chk("prio_ld_alu", result_flag_sig, 16'h0001);
        flag_op = 3'd1; alu_wr = 1; alu_status = 16'h0010; alu_upd_mask = 16'h0001; cyc();
        chk("prio_op_alu", result_flag_sig, 16'h0000);

        // Nesting
        load(16'h0300);
        int_enter = 1; cyc();
        chk("nest1_flags", result_flag_sig, 16'h0000);
        chk("nest1_empty", 16'(stack_empty), 16'd0);
        int_enter = 1; cyc();
        int_ret = 1; cyc();
        chk("nest_pop1", result_flag_sig, 16'h0000);
        int_ret = 1; cyc();
        chk("nest_pop2", result_flag_sig, 16'h0300);
        chk("nest_empty", 16'(stack_empty), 16'd1);
        chk("nest_err", 16'(err_sticky), 16'd0);

        // Overflow / underflow
        load(16'h0301);
        for (int i = 0; i < 4; i++) begin
            int_enter = 1; cyc();
        end
        chk("ovf_full", 16'(stack_full), 16'd1);
        chk("ovf_err0", 16'(err_sticky), 16'd0);
        int_enter = 1; cyc();
        chk("ovf_err1",  16'(err_sticky), 16'd1);
        chk("ovf_full2", 16'(stack_full), 16'd1);
        chk("ovf_flags", result_flag_sig, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            int_ret = 1; cyc();
        end
        chk("ovf_restore", result_flag_sig, 16'h0301);
        chk("ovf_empty",   16'(stack_empty), 16'd1);
        int_ret = 1; cyc();
        chk("udf_err",   16'(err_sticky), 16'd1);
        chk("udf_flags", result_flag_sig, 16'h0301);
        err_clr = 1; cyc();
        chk("err_clr", 16'(err_sticky), 16'd0);
        err_clr = 1; int_ret = 1; cyc();
        chk("err_set_wins", 16'(err_sticky), 16'd1);
        err_clr = 1; cyc();
        int_enter = 1; int_ret = 1; cyc();
        chk("both_err",   16'(err_sticky), 16'd1);
        chk("both_flags", result_flag_sig, 16'h0301);
        chk("both_empty", 16'(stack_empty), 16'd1);

        // Async reset mid-nesting
        int_enter = 1; cyc();
        int_enter = 1; cyc();
        chk("pre_rst_empty", 16'(stack_empty), 16'd0);
        #3 reset = 0;
        #1;
        chk("arst_flags", result_flag_sig, 16'h0000);
        chk("arst_empty", 16'(stack_empty), 16'd1);
        chk("arst_err",   16'(err_sticky), 16'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        int_ret = 1; cyc();
        chk("post_rst_udf", 16'(err_sticky), 16'd1);

        // Parity source
`ifdef FLAG_PARITY_GEN_EN
        alu_wr = 1; alu_result = 16'h0003; alu_upd_mask = 16'h0004; cyc();
        chk("pf_even", result_flag_sig, 16'h0004);
        alu_wr = 1; alu_result = 16'h0007; alu_status = 16'h0020; alu_upd_mask = 16'h0004; cyc();
        chk("pf_odd", result_flag_sig, 16'h0000);
`else
        alu_wr = 1; alu_status = 16'h0020; alu_upd_mask = 16'h0004; cyc();
        chk("pf_status", result_flag_sig, 16'h0004);
        alu_wr = 1; alu_status = 16'h0000; alu_result = 16'h0003; alu_upd_mask = 16'h0004; cyc();
        chk("pf_clear", result_flag_sig, 16'h0000);
`endif
        alu_wr = 1; alu_status = 16'h0020; alu_result = 16'h0000; alu_upd_mask = 16'h0000; cyc();
        chk("pf_masked_off", result_flag_sig, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
